// File: rtl/jk_bank_driver.sv
// Drives an external bank of JK flip-flops towards a desired value: computes
// the per-bit J/K pulse, waits for the bank to settle, verifies the readback
// and re-drives a bounded number of times before flagging an error.
module jk_bank_driver #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned SETTLE    = 1,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             ack,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] desired_q, desired_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d, result_q, result_d;
  logic             busy_q, busy_d, ack_q, ack_d, err_q, err_d;
  logic [WIDTH-1:0] want;

  // Desired value for a newly requested op, derived from the current bank state.
  always_comb begin
    want = '0;
    case (op)
      2'b00:   want = target;
      2'b01:   want = q_fb + 1'b1;  // wraps silently
      2'b10:   want = '0;
      default: want = ~q_fb;
    endcase
  end

  // Next-state and registered-output logic. Only the op's desired value is
  // kept; the op code itself is not needed after acceptance.
  always_comb begin
    state_d   = state_q;
    desired_d = desired_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    j_d       = '0;
    k_d       = '0;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    result_d  = result_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          desired_d = want;
          // J sets 0->1 bits, K clears 1->0 bits; never both on one bit.
          j_d       = ~q_fb & want;
          k_d       = q_fb & ~want;
          retry_d   = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = StDrive;
        end
      end
      StDrive: begin
        cnt_d   = '0;
        state_d = (SETTLE == 0) ? StCheck : StSettle;
      end
      StSettle: begin
        if (cnt_q == SW'(SETTLE - 1)) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (q_fb == desired_q) begin
          ack_d    = 1'b1;
          result_d = q_fb;
          state_d  = StDone;
        end else if (retry_q == RW'(MAX_RETRY)) begin
          ack_d    = 1'b1;
          err_d    = 1'b1;
          result_d = q_fb;
          state_d  = StDone;
        end else begin
          retry_d = retry_q + 1'b1;
          j_d     = ~q_fb & desired_q;
          k_d     = q_fb & ~desired_q;
          state_d = StDrive;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset clears outputs without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      desired_q <= '0;
      retry_q   <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      desired_q <= desired_d;
      retry_q   <= retry_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      result_q  <= result_d;
    end
  end

  assign j      = j_q;
  assign k      = k_q;
  assign busy   = busy_q;
  assign ack    = ack_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with a 4-bit JK bank model and an
// optional stuck-at-0 mask on the readback.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] op;
  logic [3:0] target, q_fb, j, k, result;
  logic       busy, ack, err;

  logic [3:0] bank;
  logic       ld;
  logic [3:0] ld_val;
  logic [3:0] stuck0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_drive = 0;
  int n_overlap = 0;
  int n_ack = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op     (op),
    .target (target),
    .q_fb   (q_fb),
    .j      (j),
    .k      (k),
    .busy   (busy),
    .ack    (ack),
    .err    (err),
    .result (result)
  );

  // JK bank: hold 00, set 10, clear 01; preload port for test setup.
  always @(posedge clk) begin
    if (ld) bank <= ld_val;
    else    bank <= (j & ~bank) | (~k & bank);
  end
  assign q_fb = bank & ~stuck0;

  // Running event counters, sampled away from the active edge.
  always @(negedge clk) begin
    if ((j | k) != 4'b0000) n_drive++;
    if ((j & k) != 4'b0000) n_overlap++;
    if (ack === 1'b1) n_ack++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] v);
    ld_val = v;
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // Issues one request and follows it to completion. Latency counts cycles
  // from the one carrying req (cycle 0) to the one carrying ack.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [3:0] t,
                       input logic [3:0] ej, input logic [3:0] ek, input logic [3:0] eres,
                       input logic eerr, input int elat);
    int lat;
    req = 1'b1; op = o; target = t;
    @(posedge clk); #1;
    req = 1'b0;
    check_eq({tag, "_j"}, 32'(j), 32'(ej));
    check_eq({tag, "_k"}, 32'(k), 32'(ek));
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_err_clr"}, 32'(err), 32'd0);
    lat = 1;
    while (ack !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (ack !== 1'b1) begin
      check_eq({tag, "_ack_timeout"}, 32'(ack), 32'd1);
    end else begin
      if (elat > 0) check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
      check_eq({tag, "_result"}, 32'(result), 32'(eres));
      check_eq({tag, "_err"}, 32'(err), 32'(eerr));
      @(posedge clk); #1;
      check_eq({tag, "_ack_1cyc"}, 32'(ack), 32'd0);
      check_eq({tag, "_idle"}, 32'(busy), 32'd0);
      check_eq({tag, "_err_hold"}, 32'(err), 32'(eerr));
    end
  endtask

  initial begin
    int d0, a0, acks, idles;
    rst = 1'b1; req = 1'b0; op = 2'b00; target = 4'h0;
    ld = 1'b0; ld_val = 4'h0; stuck0 = 4'h0; bank = 4'h0;
    #3;
    check_eq("rst_j", 32'(j), 32'd0);
    check_eq("rst_k", 32'(k), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load 0000 -> 1010.
    preload(4'b0000);
    d0 = n_drive;
    do_op("load", 2'b00, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 1'b0, 4);
    check_eq("load_pulses", 32'(n_drive - d0), 32'd1);

    // Increment wraps 1111 -> 0000.
    preload(4'b1111);
    do_op("incwrap", 2'b01, 4'b0101, 4'b0000, 4'b1111, 4'b0000, 1'b0, 4);

    // Complement 0110 -> 1001, no J/K overlap.
    preload(4'b0110);
    do_op("compl", 2'b11, 4'b0000, 4'b1001, 4'b0110, 4'b1001, 1'b0, 4);
    check_eq("compl_overlap", 32'(n_overlap), 32'd0);

    // Bit0 stuck at 0: one drive plus three retries, then err.
    preload(4'b0000);
    stuck0 = 4'b0001;
    d0 = n_drive;
    do_op("stuck", 2'b00, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 0);
    check_eq("stuck_pulses", 32'(n_drive - d0), 32'd4);
    stuck0 = 4'b0000;

    // Clear of an already-zero bank: empty drive, nominal latency; clears err.
    preload(4'b0000);
    do_op("clr_zero", 2'b10, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4);

    // req held high: one op per IDLE visit, period of five cycles.
    preload(4'b0000);
    acks = 0; idles = 0;
    req = 1'b1; op = 2'b01; target = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
      if (busy === 1'b0) idles++;
    end
    req = 1'b0;
    check_eq("held_acks", 32'(acks), 32'd2);
    check_eq("held_idles", 32'(idles), 32'd2);
    check_eq("held_qfb", 32'(q_fb), 32'd2);

    // Reset during SETTLE abandons the op; next req right after release.
    preload(4'b0000);
    a0 = n_ack;
    req = 1'b1; op = 2'b00; target = 4'b0011;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_j", 32'(j), 32'd0);
    check_eq("midrst_k", 32'(k), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ack", 32'(ack), 32'd0);
    check_eq("midrst_result", 32'(result), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    check_eq("midrst_noack", 32'(n_ack - a0), 32'd0);
    rst = 1'b0;
    do_op("postrst", 2'b11, 4'b0000, 4'b1100, 4'b0011, 4'b1100, 1'b0, 4);
    check_eq("postrst_acks", 32'(n_ack - a0), 32'd1);

    // Stuck run leaves err and result set; an async reset clears them.
    preload(4'b0000);
    stuck0 = 4'b0001;
    do_op("stuck2", 2'b00, 4'b0011, 4'b0011, 4'b0000, 4'b0010, 1'b1, 0);
    stuck0 = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_err", 32'(err), 32'd0);
    check_eq("arst_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    check_eq("overlap_total", 32'(n_overlap), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

Interface
REQ-001 Parameter: WIDTH, default 4, number of external JK flip-flops driven.
REQ-002 Parameter: SETTLE, default 1, idle cycles after a drive pulse before q_fb is compared.
REQ-003 Parameter: MAX_RETRY, default 3, number of re-drive attempts after a failed compare.
REQ-004 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: req  input  1  operation request, sampled only in IDLE.
REQ-007 Port: op  input  2  operation: 00 load target, 01 increment, 10 clear, 11 complement.
REQ-008 Port: target  input  WIDTH  value for op=00; ignored for all other ops.
REQ-009 Port: q_fb  input  WIDTH  Q outputs of the external JK bank.
REQ-010 Port: j  output  WIDTH  J inputs to the external bank; registered.
REQ-011 Port: k  output  WIDTH  K inputs to the external bank; registered.
REQ-012 Port: busy  output  1  high from the cycle after request acceptance until return to IDLE.
REQ-013 Port: ack  output  1  one-cycle completion pulse.
REQ-014 Port: err  output  1  failure flag, asserted with ack when retries are exhausted.
REQ-015 Port: result  output  WIDTH  q_fb captured at completion.

Function
REQ-016 FSM states SHALL be IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-017 In IDLE, req=1 SHALL latch op and compute desired (D) from current q_fb: 00->target, 01->q_fb+1 mod 2^WIDTH, 10->0, 11->~q_fb; next state DRIVE, retry count 0.
REQ-018 DRIVE SHALL last exactly one cycle, with j/k per bit from q_fb versus D: 0->0 J0 K0, 0->1 J1 K0, 1->0 J0 K1, 1->1 J0 K0.
REQ-019 j and k SHALL be 0 in every state except DRIVE, and j&k SHALL never be 1 for any bit.
REQ-020 SETTLE SHALL hold j=k=0 for exactly SETTLE cycles, then go to CHECK.
REQ-021 CHECK on q_fb==D SHALL go to DONE with err=0.
REQ-022 CHECK on mismatch with retry<MAX_RETRY SHALL increment retry and go to DRIVE, recomputing j/k from the current q_fb.
REQ-023 CHECK on mismatch with retry==MAX_RETRY SHALL go to DONE with err=1.
REQ-024 DONE SHALL last one cycle: ack=1, result=q_fb, then IDLE.
REQ-025 Nominal latency, req sampled to ack high, SHALL be 3+SETTLE cycles, i.e. 4 with defaults.
REQ-026 req while busy SHALL be ignored, with no queuing.
REQ-027 err SHALL stay high after DONE until the next request is accepted, then clear.
REQ-028 Increment of all-ones SHALL wrap to 0, with no overflow flag.
REQ-029 An op whose D equals the current q_fb SHALL still run the full sequence, with a DRIVE of all-zero j/k and ack after nominal latency.

Reset
REQ-030 rst=1 SHALL immediately, without a clock: force j=0, k=0, busy=0, ack=0, err=0, result=0, state IDLE, retry 0.
REQ-031 Reset asserted mid-operation SHALL abandon the operation, with no ack generated.
REQ-032 The first request SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-033 Bench SHALL model a 4-bit JK bank sampling j/k on rising clk, with an optional stuck-at fault injection.
REQ-034 Load: q_fb=0000, req op=00 target=1010 -> DRIVE j=1010 k=0000; ack 4 cycles later; result=1010; err=0.
REQ-035 Increment wrap: q_fb=1111, op=01 -> j=0000 k=1111; result=0000; ack after 4 cycles.
REQ-036 Complement: q_fb=0110, op=11 -> j=1001 k=0110; result=1001; no cycle with j&k!=0.
REQ-037 Stuck bit: bit0 stuck at 0, op=00 target=0001 -> 4 DRIVE pulses (1+3 retries); ack with err=1; result=0000; err clears on next accepted req.
REQ-038 Reset mid-op: assert rst during SETTLE -> j=k=busy=ack=0 asynchronously; no ack; new req after release completes normally.
REQ-039 Busy and boundary: req held high through an operation -> exactly one op per IDLE visit; op=10 with q_fb=0000 -> DRIVE j=k=0000; ack with result=0000.
